// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCD_CTRL byte writer (START/DONE) between NREQ clients,
// with LOCK bursts capped at MAX_BURST bytes and a DONE timeout that forces completion.
module lcd_write_arbiter #(
    parameter int NREQ      = 2,
    parameter int TIMEOUT   = 255,
    parameter int MAX_BURST = 32
) (
    input  logic                CLK1K,
    input  logic                RSTN,
    input  logic [NREQ-1:0]     REQ,
    input  logic [NREQ-1:0]     LOCK,
    input  logic [8*NREQ-1:0]   DATA_IN,
    input  logic [NREQ-1:0]     RS_IN,
    output logic [NREQ-1:0]     GNT,
    output logic [NREQ-1:0]     ACK,
    output logic                START_OUT,
    output logic [7:0]          DATA_OUT,
    output logic                RS_OUT,
    input  logic                DONE_IN,
    output logic                BUSY,
    output logic                TIMEOUT_ERR
);

    localparam int PW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACKC, REL} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   owner, owner_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [BW-1:0]   burst, burst_nxt;
    logic [TW-1:0]   tmo, tmo_nxt;
    logic [NREQ-1:0] gnt_nxt, ack_nxt;
    logic            start_nxt, rs_nxt, terr_nxt;
    logic [7:0]      data_nxt;

    logic            found;
    logic [PW-1:0]   win;
    int              scan_idx;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        burst_nxt = burst;
        tmo_nxt   = tmo;
        gnt_nxt   = GNT;
        ack_nxt   = '0;
        start_nxt = 1'b0;
        data_nxt  = DATA_OUT;
        rs_nxt    = RS_OUT;
        terr_nxt  = 1'b0;
        found     = 1'b0;
        win       = ptr;
        scan_idx  = 0;

        // First requester at or after the pointer, wrapping modulo NREQ.
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = (int'(ptr) + i) % NREQ;
            if (!found && REQ[scan_idx]) begin
                found = 1'b1;
                win   = PW'(scan_idx);
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = WAIT;
                    owner_nxt = win;
                    gnt_nxt   = NREQ'(1) << win;
                    data_nxt  = DATA_IN[8*win +: 8];
                    rs_nxt    = RS_IN[win];
                    start_nxt = 1'b1;
                    burst_nxt = BW'(1);
                    tmo_nxt   = '0;
                end
            end
            WAIT: begin
                tmo_nxt = tmo + TW'(1);
                // START_OUT marks the first WAIT cycle, where a stale DONE must not count.
                if (DONE_IN && !START_OUT) begin
                    ack_nxt   = NREQ'(1) << owner;
                    state_nxt = ACKC;
                end else if (tmo == TW'(TIMEOUT - 1)) begin
                    ack_nxt   = NREQ'(1) << owner;
                    terr_nxt  = 1'b1;
                    state_nxt = ACKC;
                end
            end
            ACKC: begin
                state_nxt = REL;
            end
            REL: begin
                if (REQ[owner] && LOCK[owner] && (burst < BW'(MAX_BURST))) begin
                    state_nxt = WAIT;
                    data_nxt  = DATA_IN[8*owner +: 8];
                    rs_nxt    = RS_IN[owner];
                    start_nxt = 1'b1;
                    burst_nxt = burst + BW'(1);
                    tmo_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK1K) begin
        if (!RSTN) begin
            state       <= IDLE;
            owner       <= '0;
            ptr         <= '0;
            burst       <= '0;
            tmo         <= '0;
            GNT         <= '0;
            ACK         <= '0;
            START_OUT   <= 1'b0;
            DATA_OUT    <= '0;
            RS_OUT      <= 1'b0;
            BUSY        <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            ptr         <= ptr_nxt;
            burst       <= burst_nxt;
            tmo         <= tmo_nxt;
            GNT         <= gnt_nxt;
            ACK         <= ack_nxt;
            START_OUT   <= start_nxt;
            DATA_OUT    <= data_nxt;
            RS_OUT      <= rs_nxt;
            BUSY        <= (state_nxt != IDLE);
            TIMEOUT_ERR <= terr_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: timestamp-based reference model checked every cycle,
// queue-driven clients, an LCD_CTRL stand-in with programmable DONE delay, and directed scenarios.
module tb_lcd_write_arbiter;

    localparam int N   = 2;
    localparam int TMO = 8;
    localparam int MB  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstn = 1'b0;
    logic [N-1:0]   req = '0, lock = '0, rs_in = '0;
    logic [8*N-1:0] data_in = '0;
    logic           done = 1'b0;
    logic [N-1:0]   gnt, ack;
    logic           start, rs_out, busy, terr;
    logic [7:0]     data_out;

    lcd_write_arbiter #(.NREQ(N), .TIMEOUT(TMO), .MAX_BURST(MB)) dut (
        .CLK1K(clk), .RSTN(rstn), .REQ(req), .LOCK(lock), .DATA_IN(data_in), .RS_IN(rs_in),
        .GNT(gnt), .ACK(ack), .START_OUT(start), .DATA_OUT(data_out), .RS_OUT(rs_out),
        .DONE_IN(done), .BUSY(busy), .TIMEOUT_ERR(terr)
    );

    int tests = 0, fails = 0;
    int cyc = 0;

    // Reference model: one byte is a transaction with a start cycle and an ack cycle.
    int         m_own = -1, m_start = 0, m_ack = -1, m_burst = 0, m_ptr = 0;
    logic [N-1:0] exp_gnt = '0, exp_ack = '0;
    logic       exp_start = 1'b0, exp_rs = 1'b0, exp_busy = 1'b0, exp_terr = 1'b0;
    logic [7:0] exp_data = '0;

    function automatic int rr_pick(int p, logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic model_launch(int w);
        m_own     = w;
        m_start   = cyc + 1;
        m_ack     = -1;
        exp_data  = data_in[8*w +: 8];
        exp_rs    = rs_in[w];
        exp_start = 1'b1;
    endtask

    task automatic model_step();
        exp_ack   = '0;
        exp_start = 1'b0;
        exp_terr  = 1'b0;
        if (!rstn) begin
            m_own = -1; m_ptr = 0; m_burst = 0; m_ack = -1;
            exp_data = '0; exp_rs = 1'b0;
        end else if (m_own < 0) begin
            if (req != '0) begin
                model_launch(rr_pick(m_ptr, req));
                m_burst = 1;
            end
        end else if (m_ack < 0) begin
            if (cyc > m_start && done) begin
                m_ack = cyc + 1; exp_ack[m_own] = 1'b1;
            end else if (cyc - m_start == TMO - 1) begin
                m_ack = cyc + 1; exp_ack[m_own] = 1'b1; exp_terr = 1'b1;
            end
        end else if (cyc > m_ack) begin
            if (req[m_own] && lock[m_own] && m_burst < MB) begin
                model_launch(m_own);
                m_burst++;
            end else begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end
        end
        exp_gnt  = (m_own < 0) ? '0 : (N'(1) << m_own);
        exp_busy = (m_own >= 0);
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Event logs captured by the compare process
    int         st_own[$], st_cyc[$], ack_own[$], ack_cyc[$];
    logic [7:0] st_data[$];
    logic       st_rs[$], ack_terr[$];
    int         multi_gnt = 0;

    function automatic int onehot_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            tests++;
            if ({gnt, ack, start, data_out, rs_out, busy, terr} !==
                {exp_gnt, exp_ack, exp_start, exp_data, exp_rs, exp_busy, exp_terr}) begin
                fails++;
                $display("FAIL cycle_compare @%0d: dut gnt=%b ack=%b start=%b data=%h rs=%b busy=%b terr=%b | model gnt=%b ack=%b start=%b data=%h rs=%b busy=%b terr=%b",
                         cyc, gnt, ack, start, data_out, rs_out, busy, terr,
                         exp_gnt, exp_ack, exp_start, exp_data, exp_rs, exp_busy, exp_terr);
            end
            if (start) begin
                st_own.push_back(onehot_idx(gnt)); st_cyc.push_back(cyc);
                st_data.push_back(data_out); st_rs.push_back(rs_out);
            end
            if (ack != '0) begin
                ack_own.push_back(onehot_idx(ack)); ack_cyc.push_back(cyc);
                ack_terr.push_back(terr);
            end
            if ($countones(gnt) > 1) multi_gnt++;
        end
    end

    // Clients: each presents the head of its queue and pops it on ACK. Entry = {lock, rs, data}.
    logic [9:0] q0[$], q1[$];

    initial forever begin
        @(posedge clk); #1;
        if (ack[0] && q0.size() > 0) q0.delete(0);
        if (ack[1] && q1.size() > 0) q1.delete(0);
        if (q0.size() > 0) begin
            req[0] = 1'b1; lock[0] = q0[0][9]; rs_in[0] = q0[0][8]; data_in[7:0] = q0[0][7:0];
        end else begin
            req[0] = 1'b0; lock[0] = 1'b0;
        end
        if (q1.size() > 0) begin
            req[1] = 1'b1; lock[1] = q1[0][9]; rs_in[1] = q1[0][8]; data_in[15:8] = q1[0][7:0];
        end else begin
            req[1] = 1'b0; lock[1] = 1'b0;
        end
    end

    // LCD_CTRL stand-in: DONE high for one cycle, done_delay cycles after the START cycle (-1 = never).
    int done_delay = 2;
    int dcnt = -1;
    initial forever begin
        @(posedge clk); #1;
        if (!rstn) begin
            dcnt = -1; done = 1'b0;
        end else if (start) begin
            dcnt = done_delay; done = (done_delay == 0);
        end else if (dcnt > 0) begin
            dcnt--; done = (dcnt == 0);
        end else begin
            dcnt = -1; done = 1'b0;
        end
    end

    function automatic logic [9:0] mk(logic lk, logic r, logic [7:0] d);
        return {lk, r, d};
    endfunction

    function automatic int own_at(int k);   if (k < st_own.size())   return st_own[k];        return -1; endfunction
    function automatic int data_at(int k);  if (k < st_data.size())  return int'(st_data[k]);  return -1; endfunction
    function automatic int rs_at(int k);    if (k < st_rs.size())    return int'(st_rs[k]);    return -1; endfunction
    function automatic int stcyc_at(int k); if (k < st_cyc.size())   return st_cyc[k];        return -1000; endfunction
    function automatic int ackcyc_at(int k);if (k < ack_cyc.size())  return ack_cyc[k];       return -1000; endfunction
    function automatic int terr_at(int k);  if (k < ack_terr.size()) return int'(ack_terr[k]); return -1; endfunction

    task automatic tick();
        @(negedge clk); #2;
    endtask

    task automatic check(string nm, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        st_own.delete(); st_cyc.delete(); st_data.delete(); st_rs.delete();
        ack_own.delete(); ack_cyc.delete(); ack_terr.delete();
    endtask

    task automatic wait_idle(string nm, int budget);
        int idle = 0;
        for (int n = 0; n < budget && idle < 2; n++) begin
            tick();
            if (q0.size() == 0 && q1.size() == 0 && !busy) idle++;
            else idle = 0;
        end
        check({nm, "_reached_idle"}, int'(idle >= 2), 1);
    endtask

    task automatic one_byte(string nm, int dly, int exp_lat, int exp_terr);
        clear_logs();
        done_delay = dly;
        q0.push_back(mk(1'b0, 1'b0, 8'h01));
        wait_idle(nm, 60);
        check({nm, "_acks"}, ack_own.size(), 1);
        check({nm, "_latency"}, ackcyc_at(0) - stcyc_at(0), exp_lat);
        check({nm, "_terr"}, terr_at(0), exp_terr);
    endtask

    initial begin
        int c0_acks;
        repeat (3) tick();
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_data", int'(data_out), 0);
        rstn = 1'b1;
        tick();

        // Contention without LOCK alternates 0,1,0,1
        clear_logs();
        done_delay = 2;
        q0.push_back(mk(1'b0, 1'b1, 8'h10)); q0.push_back(mk(1'b0, 1'b1, 8'h11));
        q1.push_back(mk(1'b0, 1'b0, 8'h20)); q1.push_back(mk(1'b0, 1'b0, 8'h21));
        wait_idle("t2", 200);
        check("t2_starts", st_own.size(), 4);
        check("t2_own0", own_at(0), 0); check("t2_own1", own_at(1), 1);
        check("t2_own2", own_at(2), 0); check("t2_own3", own_at(3), 1);
        check("t2_data1", data_at(1), 8'h20); check("t2_data2", data_at(2), 8'h11);
        check("t2_multi_gnt", multi_gnt, 0);

        // 26-byte locked message holds off client 1
        clear_logs();
        done_delay = 1;
        for (int k = 0; k < 26; k++) begin
            if (k == 0)       q0.push_back(mk(1'b1, 1'b0, 8'h01));
            else if (k == 12) q0.push_back(mk(1'b1, 1'b0, 8'hC0));
            else              q0.push_back(mk(1'b1, 1'b1, 8'(8'h40 + k)));
        end
        q1.push_back(mk(1'b0, 1'b1, 8'h55));
        wait_idle("t3", 1000);
        check("t3_starts", st_own.size(), 27);
        check("t3_own25", own_at(25), 0);
        check("t3_own26", own_at(26), 1);
        check("t3_data12", data_at(12), 8'hC0);
        check("t3_rs12", rs_at(12), 0);
        check("t3_data26", data_at(26), 8'h55);
        check("t3_turnaround", stcyc_at(1) - ackcyc_at(0), 2);
        c0_acks = 0;
        foreach (ack_own[k]) if (ack_own[k] == 0) c0_acks++;
        check("t3_c0_acks", c0_acks, 26);

        // Single byte, DONE 5 cycles after START
        clear_logs();
        done_delay = 5;
        q0.push_back(mk(1'b0, 1'b1, 8'h44));
        wait_idle("t1", 60);
        check("t1_starts", st_own.size(), 1);
        check("t1_own", own_at(0), 0);
        check("t1_data", data_at(0), 8'h44);
        check("t1_rs", rs_at(0), 1);
        check("t1_acks", ack_own.size(), 1);
        check("t1_latency", ackcyc_at(0) - stcyc_at(0), 6);
        check("t1_terr", terr_at(0), 0);
        check("t1_gnt_idle", int'(gnt), 0);

        // Timeout boundaries
        one_byte("t5_stuck", -1, 8, 1);
        one_byte("t5_done_at_limit", 7, 8, 0);
        one_byte("t5_done_in_start_cycle", 0, 8, 1);
        one_byte("t5_done_before_limit", 6, 7, 0);

        // Reset during WAIT: pointer sits at 1 here, so a post-reset win by client 0 shows it cleared
        clear_logs();
        done_delay = -1;
        q0.push_back(mk(1'b0, 1'b1, 8'h66));
        for (int n = 0; n < 20 && st_own.size() == 0; n++) tick();
        check("t6_started", st_own.size(), 1);
        tick(); tick();
        q1.push_back(mk(1'b0, 1'b1, 8'h77));
        rstn = 1'b0;
        tick();
        check("t6_rst_gnt", int'(gnt), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_start", int'(start), 0);
        check("t6_rst_data", int'(data_out), 0);
        check("t6_no_ack", ack_own.size(), 0);
        clear_logs();
        done_delay = 2;
        rstn = 1'b1;
        wait_idle("t6", 200);
        check("t6_own0", own_at(0), 0);
        check("t6_data0", data_at(0), 8'h66);
        check("t6_own1", own_at(1), 1);

        // MAX_BURST cap hands the grant over after byte 32
        clear_logs();
        done_delay = 1;
        for (int k = 0; k < 40; k++) q0.push_back(mk(1'b1, 1'b1, 8'(k)));
        tick(); tick(); tick();
        q1.push_back(mk(1'b0, 1'b1, 8'h99));
        wait_idle("t4", 2000);
        check("t4_starts", st_own.size(), 41);
        check("t4_own31", own_at(31), 0);
        check("t4_own32", own_at(32), 1);
        check("t4_data32", data_at(32), 8'h99);
        check("t4_own33", own_at(33), 0);
        check("final_multi_gnt", multi_gnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
